outr_serial_tx: RTL

// - Device-side end of the Basic Computer output register (OUTR): receives the byte the CPU

---
 rtl/outr_serial_tx_pkg.sv | 28 ++
 rtl/outr_serial_tx_baud_tick_gen.sv | 38 +++
 rtl/outr_serial_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/outr_serial_tx_pkg.sv
// Shared definitions for the OUTR serial transmitter and its INPR-side sibling.
// Contents: FSM state encoding, data width and the idle line level.
// Optional feature macro: OUTR_PARITY_EN
//   - Defined: the ST_PARITY state and the even-parity helper are present.
//   - Undefined: neither is present.
package outr_serial_tx_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;   // the receiver also treats this level as "line idle"

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef OUTR_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

`ifdef OUTR_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/outr_serial_tx_baud_tick_gen.sv
// baud_tick_gen: bit-period timer. The INPR-side receiver uses the same module.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   en    in  counting enable; the count is held at 0 while en is low
//   tick  out high for one cycle on the last clock of each bit period
// Parameter CLKS_PER_BIT (>=2): number of clk cycles per bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!en) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  // The tick marks the wrap, so a bit that starts at count 0 lasts exactly
  // CLKS_PER_BIT cycles.
  assign tick = en && (r_count == LAST);

endmodule

// File: rtl/outr_serial_tx.sv
// outr_serial_tx: device side of the OUTR register.
// It takes the byte written by OUT, sends it as a UART frame (LSB first), and
// sets FGO again when the frame is done.
// Ports:
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset
//   load     in  OUT executed: capture in_data if fgo==1
//   in_data  in  OUTR byte
//   fgo      out 1 = ready for a byte, 0 = transmitting
//   busy     out FSM is not idle
//   tx       out serial line, idle high
//   overrun  out one-cycle pulse for a load that arrives while fgo==0
// Parameters: CLKS_PER_BIT (>=2), STOP_BITS (1 or 2).
// Optional feature macro: OUTR_PARITY_EN adds an even-parity bit after the data bits.
module outr_serial_tx
  import outr_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] in_data,
  output logic       fgo,
  output logic       busy,
  output logic       tx,
  output logic       overrun
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = (STOP_BITS == 2);

  tx_state_t            r_state, w_state_next;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_next;
  logic [2:0]           r_bit_idx, w_bit_idx_next;
  logic                 r_stop_idx, w_stop_idx_next;
  logic                 r_fgo, w_fgo_next;
  logic                 r_tx, w_tx_next;
  logic                 r_overrun, w_overrun_next;
`ifdef OUTR_PARITY_EN
  logic                 r_parity, w_parity_next;
`endif
  logic                 w_tick;
  logic                 w_accept;

  // The baud counter runs only while a frame is active. It is held at 0 in
  // IDLE, so every accepted frame starts from a cleared count.
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (r_state != ST_IDLE),
    .tick (w_tick)
  );

  assign w_accept = load && r_fgo;

  always_comb begin
    w_state_next    = r_state;
    w_shreg_next    = r_shreg;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_fgo_next      = r_fgo;
    w_tx_next       = r_tx;
`ifdef OUTR_PARITY_EN
    w_parity_next   = r_parity;
`endif
    // This pulse fires on the final stop-tick edge too, because fgo is still 0 there.
    w_overrun_next  = load && !r_fgo;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_shreg_next    = in_data;
`ifdef OUTR_PARITY_EN
          w_parity_next   = even_parity(in_data);
`endif
          w_fgo_next      = 1'b0;
          w_tx_next       = 1'b0;   // start bit goes out on the accept edge
          w_bit_idx_next  = '0;
          w_stop_idx_next = 1'b0;
          w_state_next    = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_tx_next      = r_shreg[0];
          w_shreg_next   = {1'b0, r_shreg[DATA_BITS-1:1]};
          w_bit_idx_next = '0;
          w_state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == LAST_BIT) begin
`ifdef OUTR_PARITY_EN
            w_tx_next    = r_parity;
            w_state_next = ST_PARITY;
`else
            w_tx_next       = IDLE_LEVEL;
            w_stop_idx_next = 1'b0;
            w_state_next    = ST_STOP;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shreg[0];
            w_shreg_next   = {1'b0, r_shreg[DATA_BITS-1:1]};
          end
        end
      end
`ifdef OUTR_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_tx_next       = IDLE_LEVEL;
          w_stop_idx_next = 1'b0;
          w_state_next    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (r_stop_idx == STOP_LAST) begin
            w_tx_next    = IDLE_LEVEL;
            w_fgo_next   = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_stop_idx_next = 1'b1;
          end
        end
      end
      default: begin
        w_tx_next    = IDLE_LEVEL;
        w_fgo_next   = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_fgo      <= 1'b1;
      r_tx       <= IDLE_LEVEL;
      r_overrun  <= 1'b0;
`ifdef OUTR_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_shreg    <= w_shreg_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_fgo      <= w_fgo_next;
      r_tx       <= w_tx_next;
      r_overrun  <= w_overrun_next;
`ifdef OUTR_PARITY_EN
      r_parity   <= w_parity_next;
`endif
    end
  end

  assign fgo     = r_fgo;
  assign busy    = (r_state != ST_IDLE);
  assign tx      = r_tx;
  assign overrun = r_overrun;

endmodule
